// File: rtl/mcycle_unit_pkg.sv
// Shared constants for the multi-cycle multiply/divide engine: the op select
// encodings and the controller state encoding.
package mcycle_unit_pkg;

  localparam logic MCYCLE_MUL = 1'b0;
  localparam logic MCYCLE_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPUTING = 2'd1,
    S_DONE      = 2'd2
  } state_t;

endpackage

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) engine.
// One iteration per cycle for WIDTH cycles; Busy stalls the pipeline meanwhile.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic               r_op;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_result1;
  logic [WIDTH-1:0]   r_result2;

  logic               w_last;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH:0]   w_mul_pre;
  logic [2*WIDTH:0]   w_mul_next;
  logic [2*WIDTH:0]   w_div_sh;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH:0]   w_div_next;
  logic [2*WIDTH:0]   w_acc_next;

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  // r_opnd holds the multiplicand for multiply and the divisor for divide;
  // the other operand starts in the low half of the working register.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_mul_pre  = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:0]} : {1'b0, r_acc[2*WIDTH-1:0]};
    w_mul_next = w_mul_pre >> 1;

    w_div_sh   = {r_acc[2*WIDTH-1:0], 1'b0};
    w_div_diff = {1'b0, w_div_sh[2*WIDTH:WIDTH]} - {2'b00, r_opnd};
    if (!w_div_diff[WIDTH+1])
      w_div_next = {w_div_diff[WIDTH:0], w_div_sh[WIDTH-1:1], 1'b1};
    else
      w_div_next = w_div_sh;

    w_acc_next = (r_op == MCYCLE_DIV) ? w_div_next : w_mul_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (Start) w_state_next = S_COMPUTING;
      S_COMPUTING: if (w_last) w_state_next = S_DONE;
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_op      <= MCYCLE_MUL;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_result1 <= '0;
      r_result2 <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op    <= MCycleOp;
            r_opnd  <= (MCycleOp == MCYCLE_DIV) ? Operand2 : Operand1;
            r_acc   <= {1'b0, {WIDTH{1'b0}},
                        ((MCycleOp == MCYCLE_DIV) ? Operand1 : Operand2)};
            r_count <= '0;
          end
        end
        S_COMPUTING: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_result1 <= w_acc_next[WIDTH-1:0];
            r_result2 <= w_acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy        = ~RESET & (((r_state == S_IDLE) & Start) | (r_state == S_COMPUTING));
  assign Result1     = r_result1;
  assign Result2     = r_result2;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: directed operations push expected results into a
// queue; a negedge monitor pops and compares each time Busy drops.
module tb_mcycle_unit;
  import mcycle_unit_pkg::*;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          Start = 1'b0;
  logic          MCycleOp = 1'b0;
  logic [W-1:0]  Operand1 = '0;
  logic [W-1:0]  Operand2 = '0;
  logic [W-1:0]  Result1;
  logic [W-1:0]  Result2;
  logic          Busy;
  logic [1:0]    o_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;
  int busy_run;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // driver: launch one op, scramble operands afterwards, wait until IDLE again
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e1, input logic [W-1:0] e2);
    exp_q.push_back({e2, e1});
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    tick();
    Start = 1'b0; MCycleOp = ~op; Operand1 = $urandom; Operand2 = $urandom;
    repeat (W + 1) tick();
  endtask

  // scoreboard monitor
  initial begin
    busy_run = 0;
    last_exp = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        busy_run = 0;
        last_exp = '0;
      end else if (Busy === 1'b1) begin
        busy_run++;
        chk("hold_results", {Result2, Result1}, last_exp);
      end else if (busy_run > 0) begin
        chk("busy_len", 64'(busy_run), 64'(W + 1));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=0x%0h required=none", {Result2, Result1});
        end else begin
          last_exp = exp_q.pop_front();
          chk("result", {Result2, Result1}, last_exp);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    repeat (3) tick();
    RESET = 1'b0;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_r1", 64'(Result1), 64'd0);
    chk("reset_r2", 64'(Result2), 64'd0);
    chk("reset_state", 64'(o_dbg_state), 64'(S_IDLE));
    tick();

    run_op(MCYCLE_MUL, 32'd7, 32'd6, 32'd42, 32'd0);
    run_op(MCYCLE_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op(MCYCLE_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1);
    run_op(MCYCLE_DIV, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op(MCYCLE_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
    run_op(MCYCLE_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    // abort a multiply at cycle 10
    Start = 1'b1; MCycleOp = MCYCLE_MUL; Operand1 = 32'hFFFF; Operand2 = 32'hFFFF;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_busy_in_reset", 64'(Busy), 64'd0);
    tick();
    RESET = 1'b0;
    chk("abort_state", 64'(o_dbg_state), 64'(S_IDLE));
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_results", {Result2, Result1}, 64'd0);
    tick();
    run_op(MCYCLE_MUL, 32'd3, 32'd4, 32'd12, 32'd0);

    // Start together with RESET launches nothing
    RESET = 1'b1; Start = 1'b1; MCycleOp = MCYCLE_MUL; Operand1 = 32'd3; Operand2 = 32'd3;
    @(negedge CLK);
    chk("start_rst_busy", 64'(Busy), 64'd0);
    tick();
    RESET = 1'b0; Start = 1'b0;
    chk("start_rst_state", 64'(o_dbg_state), 64'(S_IDLE));
    @(negedge CLK);
    chk("start_rst_busy_after", 64'(Busy), 64'd0);
    tick();

    // Start held through DONE, then a divide launches from IDLE
    exp_q.push_back({32'd0, 32'd42});
    exp_q.push_back({32'd1, 32'd4});
    Start = 1'b1; MCycleOp = MCYCLE_MUL; Operand1 = 32'd7; Operand2 = 32'd6;
    tick();
    repeat (W) tick();
    chk("held_done_state", 64'(o_dbg_state), 64'(S_DONE));
    MCycleOp = MCYCLE_DIV; Operand1 = 32'd9; Operand2 = 32'd2;
    tick();
    chk("held_idle_state", 64'(o_dbg_state), 64'(S_IDLE));
    tick();
    Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom;
    repeat (W + 1) tick();

    repeat (2) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
